alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle unsigned multiply/divide sequencer for MULTU/DIVU. It holds no adder of its own:
//  each iteration borrows the shared datapath ALU (add 4'b0010 / sub 4'b0110) through a
//  req/gnt port and accumulates the 64-bit result in internal HI/LO registers.
//  It sits beside the ALU in the datapath. The control unit starts it and polls busy/done.
// PARAMETERS
//  WIDTH    32       operand/ALU width; iteration count equals WIDTH
//  ALU_ADD  4'b0010  ALUctr code driven for multiply iterations
//  ALU_SUB  4'b0110  ALUctr code driven for divide iterations
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      launch request; sampled only in IDLE
//  op          in   2      2'b00 MULTU, 2'b01 DIVU, 2'b1x reserved (start ignored)
//  src_a       in   WIDTH  multiplicand / dividend
//  src_b       in   WIDTH  multiplier / divisor
//  busy        out  1      high in RUN
//  done        out  1      one-cycle pulse in DONE; hi/lo are valid from this cycle on
//  hi          out  WIDTH  product[63:32] / remainder
//  lo          out  WIDTH  product[31:0] / quotient
//  div_by_zero out  1      set in DONE of a DIVU with src_b==0; held until the next accepted start
//  alu_req     out  1      ALU wanted this cycle (=busy)
//  alu_gnt     in   1      ALU granted; an iteration commits only on a req&gnt cycle
//  alu_a       out  WIDTH  ALU operand A (0 when not RUN)
//  alu_b       out  WIDTH  ALU operand B (0 when not RUN)
//  alu_ctr     out  4      ALUctr (4'b0000 when not RUN)
//  alu_shamt   out  5      always 0
//  alu_result  in   WIDTH  combinational ALU result for alu_a/alu_b/alu_ctr
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE; hi, lo, count, div_by_zero=0; busy, done, alu_req=0.
//  - FSM IDLE->RUN on start & op[1]==0. Latch op, src_b (as d), count=WIDTH, clear div_by_zero.
//    MULTU: hi=0, lo=src_a, d=src_b. DIVU: hi=0, lo=src_a, d=src_b.
//    DIVU with src_b==0: IDLE->DONE directly; hi=src_a, lo={WIDTH{1}}, div_by_zero=1.
//  - RUN: alu_req=1. Operands are combinational from registers, and ALU outputs stay stable while gnt=0.
//    On a gnt cycle, commit one iteration and decrement count. If count reaches 0: RUN->DONE.
//  - MULTU iteration: alu_a=hi, alu_b=lo[0]?d:0, alu_ctr=ALU_ADD.
//    c = (alu_result < hi) unsigned, which is the carry out.
//    {hi,lo} <= {c, alu_result, lo[WIDTH-1:1]}, i.e. the top WIDTH+1 bits shifted right by 1.
//  - DIVU iteration (restoring): r={hi[WIDTH-2:0],lo[WIDTH-1]}, top=hi[WIDTH-1].
//    alu_a=r, alu_b=d, alu_ctr=ALU_SUB. ok = top | (r >= d).
//    hi <= ok ? alu_result : r;  lo <= {lo[WIDTH-2:0], ok}.
//    Modular subtraction is exact when top=1.
//  - DONE: done=1 for exactly one cycle, then unconditionally ->IDLE.
//    hi/lo/div_by_zero hold until the next accepted start.
//  - Latency with gnt held high: start at cycle 0 -> RUN cycles 1..WIDTH -> done at cycle WIDTH+1.
//    Each gnt-low cycle in RUN adds one cycle. Zero-divisor DIVU: done at cycle 1.
//  - start while RUN/DONE is ignored and not queued. Reserved op: no state change, no done.
//  - src_a/src_b may change after the start cycle without effect.
//  - gnt outside RUN is ignored. Reset mid-RUN aborts with no done pulse.
// TESTING
//  1. MULTU 7*6, gnt=1 -> done at cycle 33; hi=0, lo=42; alu_ctr=4'b0010 through RUN.
//  2. MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001 (exercises carry).
//  3. DIVU 100/7 -> lo=14, hi=2. FFFFFFFF/80000001 -> lo=1, hi=7FFFFFFE (top bit path).
//     80000000/FFFFFFFF -> lo=0, hi=80000000.
//  4. DIVU 5/0 -> done at cycle 1; hi=5, lo=FFFFFFFF, div_by_zero=1.
//     Next MULTU 2*3 clears div_by_zero.
//  5. MULTU 12345678*9ABCDEF0 with gnt toggling 1/0 -> 32 granted cycles, done at cycle 64.
//     Product matches the gnt=1 run; alu_a/b stable across each gnt=0 cycle.
//  6. rst_n low at RUN iteration 10 -> immediate IDLE, hi=lo=0, no done.
//     start pulsed during RUN is ignored; op=2'b10 never asserts busy.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
//   Multi-cycle unsigned multiply/divide sequencer for MULTU and DIVU.
//   It has no adder of its own. Each iteration borrows the shared datapath ALU
//   through a req/gnt port. The sequencer builds the 64-bit result in its
//   internal HI/LO registers, one bit per granted cycle.
//
// Handshake (req/gnt):
//   alu_req is high for the whole of RUN. One iteration commits on every clock
//   edge that sees alu_req & alu_gnt. While alu_gnt is low, nothing commits.
//   The operands (alu_a/alu_b/alu_ctr) depend only on registers, so they stay
//   stable until a grant arrives. alu_gnt is ignored outside RUN.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   start, op          launch request (op 00 MULTU, 01 DIVU, 1x reserved),
//                      sampled only in IDLE
//   src_a, src_b       multiplicand/dividend and multiplier/divisor
//   busy, done         busy is high in RUN; done is a one-cycle pulse in DONE
//   hi, lo             product[63:32]/remainder and product[31:0]/quotient
//   div_by_zero        set by a DIVU with a zero divisor; held until next start
//   alu_req, alu_gnt   shared-ALU request and grant
//   alu_a, alu_b       ALU operands (zero outside RUN)
//   alu_ctr, alu_shamt ALU control code (zero outside RUN); shift amount (always 0)
//   alu_result         combinational ALU result for the current operands
//   dbg_state          current FSM state, for observation
// -----------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctr,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_d;
  logic             r_is_div;
  logic [CW-1:0]    r_count;
  logic             r_dbz;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_commit;
  logic [WIDTH-1:0] w_mul_b;
  logic             w_carry;
  logic [WIDTH-1:0] w_rem;
  logic             w_top;
  logic             w_ok;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // Reserved ops (op[1]=1) are not accepted, so they cause no state change.
  assign w_accept   = (r_state == S_IDLE) && start && !op[1];
  assign w_zero_div = op[0] && (src_b == '0);
  assign w_commit   = (r_state == S_RUN) && alu_gnt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // A zero divisor needs no iterations; its result is known at once.
          w_next_state = w_zero_div ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // When r_count is 1, this commit is the last iteration.
        if (alu_gnt && (r_count == CW'(1))) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath (the adder is the borrowed ALU)
  // ---------------------------------------------------------------------------
  always_comb begin
    // Multiply: add the multiplier into HI only when the current LSB is set.
    w_mul_b = r_lo[0] ? r_d : '0;
    // Unsigned wrap-around means the add produced a carry out.
    w_carry = (alu_result < r_hi);

    // Restoring divide: shift the next dividend bit into the partial remainder.
    // The bit shifted out of HI makes the remainder WIDTH+1 bits wide. When it
    // is set, the remainder is certainly >= d, and the modular ALU subtraction
    // still gives the exact result.
    w_rem = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    w_top = r_hi[WIDTH-1];
    w_ok  = w_top || (w_rem >= r_d);

    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_is_div) begin
      w_hi_nxt = w_ok ? alu_result : w_rem;
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ok};
    end else begin
      {w_hi_nxt, w_lo_nxt} = {w_carry, alu_result, r_lo[WIDTH-1:1]};
    end
  end

  // ALU port drive: operands come only from registers, never from alu_result.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = 4'b0000;
    if (r_state == S_RUN) begin
      if (r_is_div) begin
        alu_a   = w_rem;
        alu_b   = r_d;
        alu_ctr = ALU_SUB;
      end else begin
        alu_a   = r_hi;
        alu_b   = w_mul_b;
        alu_ctr = ALU_ADD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result / operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_d      <= '0;
      r_is_div <= 1'b0;
      r_count  <= '0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_is_div <= op[0];
      r_d      <= src_b;
      r_count  <= CW'(WIDTH);
      if (w_zero_div) begin
        r_hi  <= src_a;
        r_lo  <= '1;
        r_dbz <= 1'b1;
      end else begin
        r_hi  <= '0;
        r_lo  <= src_a;
        r_dbz <= 1'b0;
      end
    end else if (w_commit) begin
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_count <= r_count - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign alu_req     = busy;
  assign alu_shamt   = 5'd0;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_seq
//   Testbench for alu_muldiv_seq. It models the shared ALU combinationally and
//   predicts each result with plain 64-bit arithmetic (a*b, a/b, a%b). Done
//   timing is predicted from the grant schedule that the bench itself drives.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          div_by_zero;
  logic          alu_req;
  logic          alu_gnt;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_ctr;
  logic [4:0]    alu_shamt;
  logic [W-1:0]  alu_result;
  logic [1:0]    dbg_state;

  int            checks;
  int            failures;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  last_hi;
  logic [W-1:0]  last_lo;

  alu_muldiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .alu_req     (alu_req),
    .alu_gnt     (alu_gnt),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctr     (alu_ctr),
    .alu_shamt   (alu_shamt),
    .alu_result  (alu_result),
    .dbg_state   (dbg_state)
  );

  // Shared datapath ALU model
  assign alu_result = (alu_ctr == 4'b0010) ? alu_a + alu_b :
                      (alu_ctr == 4'b0110) ? alu_a - alu_b : '0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation. gmode: 0 grant always, 1 grant on odd cycles, 2 random grant.
  // inj: cycle number at which a stray DIVU start is pulsed (0 = none).
  task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int gmode, input int inj);
    bit           gs[200];
    int           done_cyc;
    int           cnt;
    logic         zero;
    logic         ebusy;
    logic [63:0]  p;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         edz;
    logic [3:0]   ectr;
    logic [W-1:0] pa;
    logic [W-1:0] pb;

    zero = (op_i == 2'b01) && (b == '0);
    if (op_i == 2'b00) begin
      p   = {32'd0, a} * {32'd0, b};
      eh  = p[63:32];
      el  = p[31:0];
      edz = 1'b0;
    end else if (zero) begin
      eh  = a;
      el  = '1;
      edz = 1'b1;
    end else begin
      eh  = a % b;
      el  = a / b;
      edz = 1'b0;
    end
    exp_q.push_back(eh);
    exp_q.push_back(el);
    ectr = op_i[0] ? 4'b0110 : 4'b0010;

    // Grant schedule; the result is due one cycle after the 32nd grant.
    cnt      = 0;
    done_cyc = 1;
    for (int k = 1; k < 200; k++) begin
      if (gmode == 0)      gs[k] = 1'b1;
      else if (gmode == 1) gs[k] = (k % 2 == 1);
      else                 gs[k] = (k > 150) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!zero && cnt < W && gs[k]) begin
        cnt++;
        if (cnt == W) done_cyc = k + 1;
      end
    end

    @(negedge clk);
    start   = 1'b1;
    op      = op_i;
    src_a   = a;
    src_b   = b;
    alu_gnt = 1'($urandom_range(0, 1));
    pa      = '0;
    pb      = '0;

    for (int k = 1; k <= done_cyc + 1; k++) begin
      @(negedge clk);
      start = (k == inj);
      if (k == inj) op = 2'b01;
      src_a   = $urandom;
      src_b   = $urandom;
      alu_gnt = gs[k];

      ebusy = !zero && (k < done_cyc);
      check("busy", busy, ebusy);
      check("done", done, k == done_cyc);
      check("alu_req", alu_req, ebusy);
      check("alu_ctr", alu_ctr, ebusy ? ectr : 4'b0000);
      check("alu_shamt", alu_shamt, 0);
      if (!ebusy) begin
        check("alu_a_idle", alu_a, 0);
        check("alu_b_idle", alu_b, 0);
      end else if (k > 1 && !gs[k-1]) begin
        check("alu_a_stable", alu_a, pa);
        check("alu_b_stable", alu_b, pb);
      end
      if (k == done_cyc) begin
        eh = exp_q.pop_front();
        el = exp_q.pop_front();
      end
      if (k >= done_cyc) begin
        check("hi", hi, eh);
        check("lo", lo, el);
        check("div_by_zero", div_by_zero, edz);
      end
      pa = alu_a;
      pb = alu_b;
    end
    start   = 1'b0;
    last_hi = eh;
    last_lo = el;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    src_a    = '0;
    src_b    = '0;
    alu_gnt  = 1'b0;
    last_hi  = '0;
    last_lo  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_alu_req", alu_req, 0);
    check("rst_alu_ctr", alu_ctr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations
    run_op(2'b00, 32'd7, 32'd6, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5);
    run_op(2'b01, 32'd100, 32'd7, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 2, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b01, 32'd5, 32'd0, 0, 1);
    run_op(2'b00, 32'd2, 32'd3, 0, 0);
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0);

    // Reset during RUN iteration 10
    @(negedge clk);
    start   = 1'b1;
    op      = 2'b00;
    src_a   = 32'hDEAD_BEEF;
    src_b   = 32'h0000_1234;
    alu_gnt = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    last_hi = '0;
    last_lo = '0;

    // A reserved op never starts
    run_op(2'b01, 32'd1000, 32'd33, 0, 0);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    src_a = $urandom;
    src_b = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("rsv_busy", busy, 0);
      check("rsv_done", done, 0);
      check("rsv_hi", hi, last_hi);
      check("rsv_lo", lo, last_lo);
    end

    // Random operations
    for (int n = 0; n < 20; n++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 2'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, int'($urandom_range(0, 2)), int'($urandom_range(0, 20)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
